demux_frame_sequencer: RTL

Sequencer for the 1:16 bit-steering demux (`vinayak_demux`) in the self-correcting message receive path. It accepts a serial bitstream over a valid/ready handshake and drives the demux select and data. It assembles a 16-bit Hamming codeword in its own register and presents it to the decoder through a second valid/ready handshake. Start-of-frame marking resynchronises the stream, and an early start-of-frame is flagged as a sync error.

---
 rtl/hamming_pkg.sv | 18 +
 rtl/demux_frame_sequencer.sv | 90 +++++++++
 2 files changed

// File: rtl/hamming_pkg.sv
// ============================================================================
// hamming_pkg : shared widths and sequencer state encoding for the receive path
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hamming_pkg;
  localparam int MSG_W = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/demux_frame_sequencer.sv
// ============================================================================
// demux_frame_sequencer : serial-to-codeword sequencer driving the 1:16 demux
// Revision              : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_frame_sequencer
  import hamming_pkg::*;
#(
  parameter int FRAME_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic             din_ready,
  output logic [SEL_W-1:0] A,
  output logic             dout,
  output logic             dout_en,
  output logic [MSG_W-1:0] frame,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             sync_err
);

  localparam logic [SEL_W-1:0] C_LAST = SEL_W'(FRAME_LEN - 1);

  state_t           r_state;
  state_t           w_next;
  logic [SEL_W-1:0] r_cnt;
  logic [MSG_W-1:0] r_frame;
  logic             r_sync_err;
  logic             w_accept;
  logic [MSG_W-1:0] w_bit;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && sof) w_next = COLLECT;
      COLLECT: if (w_accept && !sof && r_cnt == C_LAST) w_next = FULL;
      FULL:    if (frame_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Reset gates every handshake output so nothing is steered while rst is high.
  always_comb begin
    din_ready   = !rst && (r_state != FULL);
    w_accept    = din_valid && din_ready;
    dout        = din;
    dout_en     = w_accept && ((r_state == COLLECT) || sof);
    frame_valid = !rst && (r_state == FULL);
    if (rst || r_state == IDLE || (r_state == COLLECT && sof)) A = '0;
    else                                                        A = r_cnt;
  end

  assign w_bit    = MSG_W'(1) << r_cnt;
  assign frame    = r_frame;
  assign sync_err = r_sync_err;

  // Counter saturates at the last position; the FSM leaves COLLECT there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_frame    <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= 1'b0;
      if (w_accept) begin
        if (sof) begin
          r_frame    <= {{(MSG_W-1){1'b0}}, din};
          r_cnt      <= SEL_W'(1);
          r_sync_err <= (r_state == COLLECT);
        end else if (r_state == COLLECT) begin
          r_frame <= (r_frame & ~w_bit) | (din ? w_bit : '0);
          if (r_cnt != C_LAST) r_cnt <= r_cnt + SEL_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire
